// File: rtl/arp_eth_rx_pkg.sv
// Shared constants for the ARP-over-Ethernet receive parser: FSM encoding,
// fixed ARP header geometry and the Ethernet/IPv4 address length check.
package arp_eth_rx_pkg;

  localparam logic [1:0] STATE_IDLE        = 2'd0;
  localparam logic [1:0] STATE_READ_HEADER = 2'd1;
  localparam logic [1:0] STATE_WAIT_LAST   = 2'd2;

  localparam int         ARP_HDR_LEN   = 28;
  localparam logic [7:0] ARP_HLEN_ETH  = 8'd6;
  localparam logic [7:0] ARP_PLEN_IPV4 = 8'd4;
  localparam logic [7:0] ARP_LAST_PTR  = 8'(ARP_HDR_LEN - 1);

  function automatic logic isHeaderValid(input logic [7:0] hlen, input logic [7:0] plen);
    return (hlen == ARP_HLEN_ETH) && (plen == ARP_PLEN_IPV4);
  endfunction

endpackage

// File: rtl/arp_eth_rx.sv
// ARP receive parser: takes an Ethernet header plus payload byte stream and
// presents the decoded 28-byte ARP header as one registered output frame.
module arp_eth_rx
  import arp_eth_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_eth_hdr_valid,
  output logic        s_eth_hdr_ready,
  input  logic [47:0] s_eth_dest_mac,
  input  logic [47:0] s_eth_src_mac,
  input  logic [15:0] s_eth_type,
  input  logic [7:0]  s_eth_payload_axis_tdata,
  input  logic        s_eth_payload_axis_tvalid,
  output logic        s_eth_payload_axis_tready,
  input  logic        s_eth_payload_axis_tlast,
  input  logic        s_eth_payload_axis_tuser,
  output logic        m_frame_valid,
  input  logic        m_frame_ready,
  output logic [47:0] m_eth_dest_mac,
  output logic [47:0] m_eth_src_mac,
  output logic [15:0] m_eth_type,
  output logic [15:0] m_arp_htype,
  output logic [15:0] m_arp_ptype,
  output logic [7:0]  m_arp_hlen,
  output logic [7:0]  m_arp_plen,
  output logic [15:0] m_arp_oper,
  output logic [47:0] m_arp_sha,
  output logic [31:0] m_arp_spa,
  output logic [47:0] m_arp_tha,
  output logic [31:0] m_arp_tpa,
  output logic        busy,
  output logic        error_header_early_termination,
  output logic        error_invalid_header
);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [7:0]  r_ptr;
  logic        r_idle;
  logic        r_active;
  logic        r_frame_valid;
  logic        r_err_early;
  logic        r_err_invalid;

  logic [47:0] r_sh_dest, r_sh_src, r_sh_sha, r_sh_tha;
  logic [15:0] r_sh_type, r_sh_htype, r_sh_ptype, r_sh_oper;
  logic [7:0]  r_sh_hlen, r_sh_plen;
  logic [31:0] r_sh_spa, r_sh_tpa;

  logic [47:0] r_m_dest, r_m_src, r_m_sha, r_m_tha;
  logic [15:0] r_m_type, r_m_htype, r_m_ptype, r_m_oper;
  logic [7:0]  r_m_hlen, r_m_plen;
  logic [31:0] r_m_spa, r_m_tpa;

  logic        w_hdr_ready;
  logic        w_hdr_hs;
  logic        w_beat;
  logic        w_last_ptr;
  logic        w_complete;
  logic        w_early;
  logic        w_hdr_ok;
  logic        w_frame_ok;
  logic        w_frame_bad;
  logic [31:0] w_tpa_final;

  // Ready is registered from the next state, then qualified in-cycle so a
  // pending frame and a new header can hand off on the same edge.
  assign w_hdr_ready = r_idle && (!r_frame_valid || m_frame_ready);
  assign w_hdr_hs    = s_eth_hdr_valid && w_hdr_ready;
  assign w_beat      = s_eth_payload_axis_tvalid && r_active;
  assign w_last_ptr  = (r_ptr == ARP_LAST_PTR);
  assign w_complete  = w_beat && s_eth_payload_axis_tlast &&
                       (((r_state == STATE_READ_HEADER) && w_last_ptr) ||
                        (r_state == STATE_WAIT_LAST));
  assign w_early     = w_beat && s_eth_payload_axis_tlast &&
                       (r_state == STATE_READ_HEADER) && !w_last_ptr;
  assign w_hdr_ok    = isHeaderValid(r_sh_hlen, r_sh_plen);
  assign w_frame_ok  = w_complete && !s_eth_payload_axis_tuser && w_hdr_ok;
  assign w_frame_bad = w_complete && !s_eth_payload_axis_tuser && !w_hdr_ok;
  assign w_tpa_final = (r_state == STATE_READ_HEADER) ?
                       {r_sh_tpa[23:0], s_eth_payload_axis_tdata} : r_sh_tpa;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      STATE_IDLE: begin
        if (w_hdr_hs) w_state_next = STATE_READ_HEADER;
      end
      STATE_READ_HEADER: begin
        if (w_beat) begin
          if (s_eth_payload_axis_tlast) w_state_next = STATE_IDLE;
          else if (w_last_ptr)          w_state_next = STATE_WAIT_LAST;
        end
      end
      STATE_WAIT_LAST: begin
        if (w_beat && s_eth_payload_axis_tlast) w_state_next = STATE_IDLE;
      end
      default: w_state_next = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= STATE_IDLE;
      r_ptr         <= 8'd0;
      r_idle        <= 1'b0;
      r_active      <= 1'b0;
      r_frame_valid <= 1'b0;
      r_err_early   <= 1'b0;
      r_err_invalid <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_idle        <= (w_state_next == STATE_IDLE);
      r_active      <= (w_state_next != STATE_IDLE);
      r_err_early   <= w_early;
      r_err_invalid <= w_frame_bad;
      if (w_hdr_hs)
        r_ptr <= 8'd0;
      else if ((r_state == STATE_READ_HEADER) && w_beat)
        r_ptr <= r_ptr + 8'd1;
      if (w_frame_ok)
        r_frame_valid <= 1'b1;
      else if (m_frame_ready)
        r_frame_valid <= 1'b0;
    end
  end

  // Multi-byte fields arrive MSB first, so each one is a left shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_dest  <= '0;
      r_sh_src   <= '0;
      r_sh_type  <= '0;
      r_sh_htype <= '0;
      r_sh_ptype <= '0;
      r_sh_hlen  <= '0;
      r_sh_plen  <= '0;
      r_sh_oper  <= '0;
      r_sh_sha   <= '0;
      r_sh_spa   <= '0;
      r_sh_tha   <= '0;
      r_sh_tpa   <= '0;
    end else begin
      if (w_hdr_hs) begin
        r_sh_dest <= s_eth_dest_mac;
        r_sh_src  <= s_eth_src_mac;
        r_sh_type <= s_eth_type;
      end
      if ((r_state == STATE_READ_HEADER) && w_beat) begin
        if (r_ptr <= 8'd1)
          r_sh_htype <= {r_sh_htype[7:0], s_eth_payload_axis_tdata};
        else if (r_ptr <= 8'd3)
          r_sh_ptype <= {r_sh_ptype[7:0], s_eth_payload_axis_tdata};
        else if (r_ptr == 8'd4)
          r_sh_hlen <= s_eth_payload_axis_tdata;
        else if (r_ptr == 8'd5)
          r_sh_plen <= s_eth_payload_axis_tdata;
        else if (r_ptr <= 8'd7)
          r_sh_oper <= {r_sh_oper[7:0], s_eth_payload_axis_tdata};
        else if (r_ptr <= 8'd13)
          r_sh_sha <= {r_sh_sha[39:0], s_eth_payload_axis_tdata};
        else if (r_ptr <= 8'd17)
          r_sh_spa <= {r_sh_spa[23:0], s_eth_payload_axis_tdata};
        else if (r_ptr <= 8'd23)
          r_sh_tha <= {r_sh_tha[39:0], s_eth_payload_axis_tdata};
        else if (r_ptr <= ARP_LAST_PTR)
          r_sh_tpa <= {r_sh_tpa[23:0], s_eth_payload_axis_tdata};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_dest  <= '0;
      r_m_src   <= '0;
      r_m_type  <= '0;
      r_m_htype <= '0;
      r_m_ptype <= '0;
      r_m_hlen  <= '0;
      r_m_plen  <= '0;
      r_m_oper  <= '0;
      r_m_sha   <= '0;
      r_m_spa   <= '0;
      r_m_tha   <= '0;
      r_m_tpa   <= '0;
    end else if (w_frame_ok) begin
      r_m_dest  <= r_sh_dest;
      r_m_src   <= r_sh_src;
      r_m_type  <= r_sh_type;
      r_m_htype <= r_sh_htype;
      r_m_ptype <= r_sh_ptype;
      r_m_hlen  <= r_sh_hlen;
      r_m_plen  <= r_sh_plen;
      r_m_oper  <= r_sh_oper;
      r_m_sha   <= r_sh_sha;
      r_m_spa   <= r_sh_spa;
      r_m_tha   <= r_sh_tha;
      r_m_tpa   <= w_tpa_final;
    end
  end

  assign s_eth_hdr_ready                = w_hdr_ready;
  assign s_eth_payload_axis_tready      = r_active;
  assign busy                           = r_active;
  assign m_frame_valid                  = r_frame_valid;
  assign error_header_early_termination = r_err_early;
  assign error_invalid_header           = r_err_invalid;
  assign m_eth_dest_mac                 = r_m_dest;
  assign m_eth_src_mac                  = r_m_src;
  assign m_eth_type                     = r_m_type;
  assign m_arp_htype                    = r_m_htype;
  assign m_arp_ptype                    = r_m_ptype;
  assign m_arp_hlen                     = r_m_hlen;
  assign m_arp_plen                     = r_m_plen;
  assign m_arp_oper                     = r_m_oper;
  assign m_arp_sha                      = r_m_sha;
  assign m_arp_spa                      = r_m_spa;
  assign m_arp_tha                      = r_m_tha;
  assign m_arp_tpa                      = r_m_tpa;

endmodule

// File: tb/tb_arp_eth_rx.sv
// Directed bench for arp_eth_rx: drives inputs on the falling edge and checks
// outputs against hand-computed ARP field values.
module tb_arp_eth_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_eth_hdr_valid = 1'b0;
  logic        s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac = '0;
  logic [47:0] s_eth_src_mac = '0;
  logic [15:0] s_eth_type = '0;
  logic [7:0]  s_eth_payload_axis_tdata = '0;
  logic        s_eth_payload_axis_tvalid = 1'b0;
  logic        s_eth_payload_axis_tready;
  logic        s_eth_payload_axis_tlast = 1'b0;
  logic        s_eth_payload_axis_tuser = 1'b0;
  logic        m_frame_valid;
  logic        m_frame_ready = 1'b0;
  logic [47:0] m_eth_dest_mac, m_eth_src_mac;
  logic [15:0] m_eth_type, m_arp_htype, m_arp_ptype, m_arp_oper;
  logic [7:0]  m_arp_hlen, m_arp_plen;
  logic [47:0] m_arp_sha, m_arp_tha;
  logic [31:0] m_arp_spa, m_arp_tpa;
  logic        busy, error_header_early_termination, error_invalid_header;

  int passCount = 0;
  int checkCount = 0;
  int frameCnt = 0;
  int earlyCnt = 0;
  int invCnt = 0;
  logic prevValid = 1'b0;
  logic busyLost;
  logic [7:0] frameBytes [0:63];

  arp_eth_rx dut (
    .clk(clk), .rst_n(rst_n),
    .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
    .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
    .s_eth_payload_axis_tdata(s_eth_payload_axis_tdata),
    .s_eth_payload_axis_tvalid(s_eth_payload_axis_tvalid),
    .s_eth_payload_axis_tready(s_eth_payload_axis_tready),
    .s_eth_payload_axis_tlast(s_eth_payload_axis_tlast),
    .s_eth_payload_axis_tuser(s_eth_payload_axis_tuser),
    .m_frame_valid(m_frame_valid), .m_frame_ready(m_frame_ready),
    .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
    .m_arp_htype(m_arp_htype), .m_arp_ptype(m_arp_ptype),
    .m_arp_hlen(m_arp_hlen), .m_arp_plen(m_arp_plen), .m_arp_oper(m_arp_oper),
    .m_arp_sha(m_arp_sha), .m_arp_spa(m_arp_spa), .m_arp_tha(m_arp_tha), .m_arp_tpa(m_arp_tpa),
    .busy(busy),
    .error_header_early_termination(error_header_early_termination),
    .error_invalid_header(error_invalid_header)
  );

  always #5 clk = ~clk;

  // Event counters: errors count cycles high, frames count rising edges of valid.
  always @(negedge clk) begin
    if (error_header_early_termination) earlyCnt++;
    if (error_invalid_header) invCnt++;
    if (m_frame_valid && !prevValid) frameCnt++;
    prevValid = m_frame_valid;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic buildFrame(input logic [15:0] oper, input logic [47:0] sha, input logic [31:0] spa,
                            input logic [47:0] tha, input logic [31:0] tpa, input logic [7:0] hlen);
    for (int i = 0; i < 64; i++) frameBytes[i] = 8'hA5;
    frameBytes[0] = 8'h00; frameBytes[1] = 8'h01;
    frameBytes[2] = 8'h08; frameBytes[3] = 8'h00;
    frameBytes[4] = hlen;  frameBytes[5] = 8'h04;
    frameBytes[6] = oper[15:8]; frameBytes[7] = oper[7:0];
    for (int k = 0; k < 6; k++) frameBytes[8 + k]  = sha[47 - 8*k -: 8];
    for (int k = 0; k < 4; k++) frameBytes[14 + k] = spa[31 - 8*k -: 8];
    for (int k = 0; k < 6; k++) frameBytes[18 + k] = tha[47 - 8*k -: 8];
    for (int k = 0; k < 4; k++) frameBytes[24 + k] = tpa[31 - 8*k -: 8];
  endtask

  task automatic sendHeader(input logic [47:0] dest, input logic [47:0] src, input logic [15:0] etype);
    int n;
    @(negedge clk);
    s_eth_hdr_valid = 1'b1;
    s_eth_dest_mac = dest;
    s_eth_src_mac = src;
    s_eth_type = etype;
    #1;
    n = 0;
    while (!s_eth_hdr_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) checkOutput("hdrTimeout", 0, 1);
    @(negedge clk);
    s_eth_hdr_valid = 1'b0;
  endtask

  task automatic sendBytes(input int first, input int last, input bit markLast, input bit userOnLast);
    int n;
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      s_eth_payload_axis_tdata = frameBytes[i];
      s_eth_payload_axis_tvalid = 1'b1;
      s_eth_payload_axis_tlast = markLast && (i == last);
      s_eth_payload_axis_tuser = markLast && (i == last) && userOnLast;
      #1;
      n = 0;
      while (!s_eth_payload_axis_tready && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (n >= 100) checkOutput("treadyTimeout", 0, 1);
      if (!busy) busyLost = 1'b1;
    end
    @(negedge clk);
    s_eth_payload_axis_tvalid = 1'b0;
    s_eth_payload_axis_tlast = 1'b0;
    s_eth_payload_axis_tuser = 1'b0;
    #1;
  endtask

  task automatic applyStimulus(input logic [47:0] dest, input logic [47:0] src, input int lastIdx,
                               input bit userOnLast);
    sendHeader(dest, src, 16'h0806);
    sendBytes(0, lastIdx, 1'b1, userOnLast);
  endtask

  task automatic ackFrame(input string tag);
    @(negedge clk);
    m_frame_ready = 1'b1;
    #1;
    checkOutput({tag, "HdrReadyOnAck"}, s_eth_hdr_ready, 1);
    @(negedge clk);
    m_frame_ready = 1'b0;
    #1;
    checkOutput({tag, "ValidCleared"}, m_frame_valid, 0);
  endtask

  initial begin
    int f0, e0, i0;
    logic readySeen, unstable, treadySeen;
    $display("[TB] arp_eth_rx directed test start");

    // Reset state
    #3;
    checkOutput("rstHdrReady", s_eth_hdr_ready, 0);
    checkOutput("rstTready", s_eth_payload_axis_tready, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstValid", m_frame_valid, 0);
    checkOutput("rstSpa", m_arp_spa, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("idleHdrReady", s_eth_hdr_ready, 1);
    checkOutput("idleTready", s_eth_payload_axis_tready, 0);

    // Plain 28-byte ARP request
    buildFrame(16'h0001, 48'h020000000001, 32'hC0A80164, 48'h0, 32'hC0A80101, 8'd6);
    applyStimulus(48'hFFFFFFFFFFFF, 48'h020000000001, 27, 1'b0);
    checkOutput("aValidLatency", m_frame_valid, 1);
    checkOutput("aFrameCnt", frameCnt, 1);
    checkOutput("aHtype", m_arp_htype, 16'h0001);
    checkOutput("aPtype", m_arp_ptype, 16'h0800);
    checkOutput("aHlen", m_arp_hlen, 8'd6);
    checkOutput("aPlen", m_arp_plen, 8'd4);
    checkOutput("aOper", m_arp_oper, 16'h0001);
    checkOutput("aSha", m_arp_sha, 48'h020000000001);
    checkOutput("aSpa", m_arp_spa, 32'hC0A80164);
    checkOutput("aTha", m_arp_tha, 48'h0);
    checkOutput("aTpa", m_arp_tpa, 32'hC0A80101);
    checkOutput("aEthDest", m_eth_dest_mac, 48'hFFFFFFFFFFFF);
    checkOutput("aEthSrc", m_eth_src_mac, 48'h020000000001);
    checkOutput("aEthType", m_eth_type, 16'h0806);
    checkOutput("aBusyIdle", busy, 0);
    checkOutput("aHdrReadyHeld", s_eth_hdr_ready, 0);
    ackFrame("a");

    // Frame followed by 18 padding bytes, tlast on byte 45
    buildFrame(16'h0002, 48'h0A0B0C0D0E0F, 32'hC0A80101, 48'h020000000001, 32'h0A000001, 8'd6);
    busyLost = 1'b0;
    sendHeader(48'h020000000001, 48'h0A0B0C0D0E0F, 16'h0806);
    sendBytes(0, 44, 1'b0, 1'b0);
    checkOutput("bNoEarlyValid", m_frame_valid, 0);
    checkOutput("bBusyInPad", busy, 1);
    sendBytes(45, 45, 1'b1, 1'b0);
    checkOutput("bBusyThroughout", busyLost, 0);
    checkOutput("bValid", m_frame_valid, 1);
    checkOutput("bFrameCnt", frameCnt, 2);
    checkOutput("bOper", m_arp_oper, 16'h0002);
    checkOutput("bTha", m_arp_tha, 48'h020000000001);
    checkOutput("bTpa", m_arp_tpa, 32'h0A000001);
    ackFrame("b");

    // Early termination at byte 20
    buildFrame(16'h0001, 48'h020000000001, 32'hC0A80164, 48'h0, 32'hC0A80101, 8'd6);
    f0 = frameCnt; e0 = earlyCnt; i0 = invCnt;
    applyStimulus(48'hFFFFFFFFFFFF, 48'h020000000001, 20, 1'b0);
    checkOutput("earlyPulse", error_header_early_termination, 1);
    checkOutput("earlyBusy", busy, 0);
    @(negedge clk);
    #1;
    checkOutput("earlyPulseCnt", earlyCnt - e0, 1);
    checkOutput("earlyNoFrame", frameCnt - f0, 0);
    checkOutput("earlyNoInvalid", invCnt - i0, 0);

    // hlen = 8 gives an invalid-header pulse
    buildFrame(16'h0001, 48'h020000000001, 32'hC0A80164, 48'h0, 32'hC0A80101, 8'd8);
    f0 = frameCnt; e0 = earlyCnt; i0 = invCnt;
    applyStimulus(48'hFFFFFFFFFFFF, 48'h020000000001, 27, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("invPulseCnt", invCnt - i0, 1);
    checkOutput("invNoFrame", frameCnt - f0, 0);
    checkOutput("invNoEarly", earlyCnt - e0, 0);

    // tuser on the last beat drops the frame silently
    buildFrame(16'h0001, 48'h020000000001, 32'hC0A80164, 48'h0, 32'hC0A80101, 8'd6);
    f0 = frameCnt; e0 = earlyCnt; i0 = invCnt;
    applyStimulus(48'hFFFFFFFFFFFF, 48'h020000000001, 27, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("userNoFrame", frameCnt - f0, 0);
    checkOutput("userNoErrors", (earlyCnt - e0) + (invCnt - i0), 0);
    checkOutput("userIdle", busy, 0);

    // Backpressure: hold frame A for 10 cycles with a second header pending
    applyStimulus(48'hFFFFFFFFFFFF, 48'h020000000001, 27, 1'b0);
    checkOutput("stallFirstValid", m_frame_valid, 1);
    buildFrame(16'h0002, 48'h0A0B0C0D0E0F, 32'hC0A80101, 48'h020000000001, 32'hC0A80164, 8'd6);
    readySeen = 1'b0;
    unstable = 1'b0;
    fork
      begin
        sendHeader(48'h020000000001, 48'h0A0B0C0D0E0F, 16'h0806);
        sendBytes(0, 27, 1'b1, 1'b0);
      end
      begin
        repeat (10) begin
          @(negedge clk);
          #2;
          if (s_eth_hdr_ready) readySeen = 1'b1;
          if (!m_frame_valid || m_arp_spa != 32'hC0A80164 || m_arp_oper != 16'h0001) unstable = 1'b1;
        end
        @(negedge clk);
        m_frame_ready = 1'b1;
        @(negedge clk);
        m_frame_ready = 1'b0;
      end
    join
    checkOutput("stallHdrReadyLow", readySeen, 0);
    checkOutput("stallFieldsStable", unstable, 0);
    checkOutput("stallSecondValid", m_frame_valid, 1);
    checkOutput("stallSecondOper", m_arp_oper, 16'h0002);
    checkOutput("stallSecondSpa", m_arp_spa, 32'hC0A80101);
    checkOutput("stallSecondTpa", m_arp_tpa, 32'hC0A80164);
    checkOutput("stallSecondSrc", m_eth_src_mac, 48'h0A0B0C0D0E0F);
    ackFrame("stall");

    // Reset asserted at byte 12 of a frame
    buildFrame(16'h0001, 48'h020000000001, 32'hC0A80164, 48'h0, 32'hC0A80101, 8'd6);
    sendHeader(48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0806);
    sendBytes(0, 11, 1'b0, 1'b0);
    f0 = frameCnt; e0 = earlyCnt; i0 = invCnt;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstSpa", m_arp_spa, 0);
    checkOutput("midRstSrc", m_eth_src_mac, 0);
    checkOutput("midRstOper", m_arp_oper, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstTready", s_eth_payload_axis_tready, 0);
    checkOutput("midRstHdrReady", s_eth_hdr_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    treadySeen = 1'b0;
    for (int i = 12; i <= 27; i++) begin
      @(negedge clk);
      s_eth_payload_axis_tdata = frameBytes[i];
      s_eth_payload_axis_tvalid = 1'b1;
      s_eth_payload_axis_tlast = (i == 27);
      #1;
      if (s_eth_payload_axis_tready) treadySeen = 1'b1;
    end
    @(negedge clk);
    s_eth_payload_axis_tvalid = 1'b0;
    s_eth_payload_axis_tlast = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("postRstTreadyLow", treadySeen, 0);
    checkOutput("postRstNoFrame", frameCnt - f0, 0);
    checkOutput("postRstNoErrors", (earlyCnt - e0) + (invCnt - i0), 0);
    applyStimulus(48'hFFFFFFFFFFFF, 48'h020000000001, 27, 1'b0);
    checkOutput("postRstValid", m_frame_valid, 1);
    checkOutput("postRstSpa", m_arp_spa, 32'hC0A80164);
    checkOutput("postRstTpa", m_arp_tpa, 32'hC0A80101);
    checkOutput("postRstSha", m_arp_sha, 48'h020000000001);
    ackFrame("postRst");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
